// File: rtl/ct_spsram_2048x32_ctrl.sv
// Valid/ready initiator for the 2048x32 single-port SRAM macro, with registered macro port and 4-entry read FIFO.
// Define CT_SPSRAM_INIT_CLR_EN to zero-clear the whole array after reset before traffic is accepted.
module ct_spsram_2048x32_ctrl #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;

   logic                  init_wr;
   logic [ADDR_WIDTH-1:0] init_addr;

`ifdef CT_SPSRAM_INIT_CLR_EN
   typedef enum logic {ST_INIT, ST_DONE} state_e;
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // The last address issued is the exit condition; the wrap back to 0 is never written.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
         if (init_cnt_q == '1) state_d = ST_DONE;
      end
   end

   always_comb begin
      init_wr   = (state_q == ST_INIT);
      init_done = (state_q == ST_DONE);
      init_addr = init_cnt_q;
   end
`else
   assign init_wr   = 1'b0;
   assign init_done = 1'b1;
   assign init_addr = '0;
`endif

   logic                                 acc, push, pop;
   logic                                 s1_rd_q, s1_rd_d, s2_rd_q, s2_rd_d;
   logic [ADDR_WIDTH-1:0]                sram_a_q, sram_a_d;
   logic                                 sram_cen_q, sram_cen_d;
   logic                                 sram_gwen_q, sram_gwen_d;
   logic [DATA_WIDTH-1:0]                sram_wen_q, sram_wen_d;
   logic [DATA_WIDTH-1:0]                sram_d_q, sram_d_d;
   logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] fifo_q, fifo_d;
   logic [PW-1:0]                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                        cnt_q, cnt_d, occ;

   // Credit covers reads still in the pipe, so a push can never find the FIFO full.
   assign occ      = cnt_q + CW'(s1_rd_q) + CW'(s2_rd_q);
   assign req_rdy  = init_done && (occ < CW'(RSP_DEPTH));
   assign acc      = req_vld && req_rdy;
   assign push     = s2_rd_q;
   assign rsp_vld  = (cnt_q != '0);
   assign rsp_data = fifo_q[rd_ptr_q];
   assign pop      = rsp_vld && rsp_rdy;

   assign sram_a    = sram_a_q;
   assign sram_cen  = sram_cen_q;
   assign sram_gwen = sram_gwen_q;
   assign sram_wen  = sram_wen_q;
   assign sram_d    = sram_d_q;

   always_comb begin
      sram_a_d    = sram_a_q;
      sram_d_d    = sram_d_q;
      sram_cen_d  = 1'b1;
      sram_gwen_d = 1'b1;
      sram_wen_d  = '1;
      if (init_wr) begin
         sram_a_d    = init_addr;
         sram_d_d    = '0;
         sram_cen_d  = 1'b0;
         sram_gwen_d = 1'b0;
         sram_wen_d  = '0;
      end else if (acc) begin
         sram_a_d   = req_addr;
         sram_cen_d = 1'b0;
         if (req_wr) begin
            sram_gwen_d = 1'b0;
            sram_wen_d  = ~req_wmask;
            sram_d_d    = req_wdata;
         end
      end
      s1_rd_d = acc && !req_wr;
      s2_rd_d = s1_rd_q;
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         fifo_d[wr_ptr_q] = sram_q;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         sram_a_q    <= '0;
         sram_d_q    <= '0;
         sram_cen_q  <= 1'b1;
         sram_gwen_q <= 1'b1;
         sram_wen_q  <= '1;
         s1_rd_q     <= 1'b0;
         s2_rd_q     <= 1'b0;
         fifo_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         sram_a_q    <= sram_a_d;
         sram_d_q    <= sram_d_d;
         sram_cen_q  <= sram_cen_d;
         sram_gwen_q <= sram_gwen_d;
         sram_wen_q  <= sram_wen_d;
         s1_rd_q     <= s1_rd_d;
         s2_rd_q     <= s2_rd_d;
         fifo_q      <= fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule
